// File: rtl/button_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_pkg: shared channel FSM encoding and counter sizing helper |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package button_pkg;

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_WAIT_DELAY = 2'd1,
      ST_REPEATING  = 2'd2
   } btn_state_e;

   // Sized for the larger terminal count; the counter clears at every terminal count.
   function automatic int cnt_width(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return $clog2(m + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/button_event_gen_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_gen_if: button levels in, per-channel event pulses out|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface button_event_gen_if #(
   parameter int width = 1
);
   logic [width-1:0] debounced_signal;
   logic             repeat_en;
   logic [width-1:0] press_pulse;
   logic [width-1:0] release_pulse;
   logic [width-1:0] repeat_pulse;
   logic [width-1:0] held;

   modport master (
      output debounced_signal, repeat_en,
      input  press_pulse, release_pulse, repeat_pulse, held
   );

   modport slave (
      input  debounced_signal, repeat_en,
      output press_pulse, release_pulse, repeat_pulse, held
   );
endinterface
`default_nettype wire

// File: rtl/button_event_channel.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_channel: one button's press/release/repeat FSM      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module button_event_channel
   import button_pkg::*;
#(
   parameter int repeat_delay_max  = 25000000,
   parameter int repeat_period_max = 5000000,
   parameter int CNT_W             = cnt_width(repeat_delay_max, repeat_period_max)
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   input  logic repeat_en_i,
   output logic press_o,
   output logic release_o,
   output logic repeat_o,
   output logic held_o
);

   // The counter holds the number of counted edges already elapsed, so the
   // terminal value is one less than the cycle count.
   localparam logic [CNT_W-1:0] DELAY_TC  = CNT_W'(repeat_delay_max - 1);
   localparam logic [CNT_W-1:0] PERIOD_TC = CNT_W'(repeat_period_max - 1);

   btn_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             repeat_q, repeat_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      repeat_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sig_i) begin
               state_d = ST_WAIT_DELAY;
               cnt_d   = '0;
               press_d = 1'b1;
            end
         end
         ST_WAIT_DELAY: begin
            if (!sig_i) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (repeat_en_i) begin
               if (cnt_q == DELAY_TC) begin
                  state_d  = ST_REPEATING;
                  cnt_d    = '0;
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         ST_REPEATING: begin
            // Release is tested first so it wins over a coinciding repeat.
            if (!sig_i) begin
               state_d   = ST_IDLE;
               cnt_d     = '0;
               release_d = 1'b1;
            end else if (repeat_en_i) begin
               if (cnt_q == PERIOD_TC) begin
                  cnt_d    = '0;
                  repeat_d = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign press_o   = press_q;
   assign release_o = release_q;
   assign repeat_o  = repeat_q;
   assign held_o    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | button_event_gen: independent press/release/auto-repeat channels |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module button_event_gen
   import button_pkg::*;
#(
   parameter int width             = 1,
   parameter int repeat_delay_max  = 25000000,
   parameter int repeat_period_max = 5000000
) (
   input  logic               clk,
   input  logic               rst,
   button_event_gen_if.slave  bus
);

   localparam int CNT_W = cnt_width(repeat_delay_max, repeat_period_max);

   for (genvar i = 0; i < width; i++) begin : g_chan
      button_event_channel #(
         .repeat_delay_max  (repeat_delay_max),
         .repeat_period_max (repeat_period_max),
         .CNT_W             (CNT_W)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .sig_i       (bus.debounced_signal[i]),
         .repeat_en_i (bus.repeat_en),
         .press_o     (bus.press_pulse[i]),
         .release_o   (bus.release_pulse[i]),
         .repeat_o    (bus.repeat_pulse[i]),
         .held_o      (bus.held[i])
      );
   end

endmodule
`default_nettype wire
